serial_normalizer_32: RTL and testbench
=======================================

SERIAL_NORMALIZER_32 -- requirements
Module: serial_normalizer_32

Interface
REQ-001 Clk  input  1  single clock; all state updates on the rising edge.
REQ-002 Clrn  input  1  reset, asynchronous, active-low; clears all state immediately, independent of Clk.
REQ-003 Start  input  1  request; sampled on rising Clk, accepted only when Busy=0.
REQ-004 X  input  32  operand, sampled on the accepting edge only.
REQ-005 Signed  input  1  mode, sampled with X: 0 = shift out leading zeros, 1 = shift out redundant sign bits.
REQ-006 Busy  output  1  high while a normalization is in progress.
REQ-007 Done  output  1  one-cycle pulse, result valid.
REQ-008 Sh  output  32  normalized value, X shifted left by Sa, zeros fill the vacated low bits.
REQ-009 Sa  output  5  left-shift amount applied.
REQ-010 Zero  output  1  operand had no normalizing bit: X=0 (Signed=0), or X=0 or X=0xFFFFFFFF (Signed=1).

Function
REQ-011 States: IDLE, RUN; 3-bit step counter K; working registers W[31:0], A[4:0], mode flag M.
REQ-012 IDLE with Start=1 at an edge: W<=X, A<=0, M<=Signed, K<=4, Busy<=1, go to RUN.
REQ-013 IDLE with Start=0: all registers hold.
REQ-014 RUN step, one per edge, K=4,3,2,1,0 in order; n=2^K.
REQ-015 Test for M=0: W[31:32-n] all zero.
REQ-016 Test for M=1: W[31:31-n] (n+1 bits) all equal to W[31].
REQ-017 Test true: W<=W<<n with zero fill, A<=A+n; test false: W and A hold.
REQ-018 A never exceeds 31, so it needs no overflow handling.
REQ-019 Step K=0: Busy<=0, Done<=1, Zero<=result of the final check, state<=IDLE.
REQ-020 Final check: Zero=1 when M=0 and W=0, or when M=1 and W[30:0]=0.
REQ-021 Latency: Start sampled at edge E; Done=1 in the cycle after edge E+5; fixed, independent of data.
REQ-022 Done is high for exactly one cycle, cleared on the next edge.
REQ-023 Sh=W and Sa=A continuously; values are valid from Done until the next accepted Start.
REQ-024 Zero holds its value until the next Done.
REQ-025 Start while Busy=1 is ignored, with no queuing and no effect on the operation in flight.
REQ-026 Start in the Done cycle is accepted, since the state is IDLE; the next Done follows 6 edges later.
REQ-027 X and Signed changes after acceptance have no effect on the running operation.
REQ-028 Result invariant, M=0 and Zero=0: Sh[31]=1 and Sh = X<<Sa.
REQ-029 Result invariant, M=1 and Zero=0: Sh[31]!=Sh[30] and Sh = X<<Sa.
REQ-030 X already normalized: every test fails, Sa=0, Sh=X.

Reset
REQ-031 Clrn=0 forces state=IDLE, K=0, W=0, A=0, M=0, Busy=0, Done=0, Zero=0; visible outputs are Sh=0, Sa=0.
REQ-032 Clrn asserted mid-RUN aborts the operation with no Done pulse.
REQ-033 After Clrn deasserts, the first edge with Start=1 begins a fresh operation.

Verification
REQ-034 Start with X=0x00000001, Signed=0: after 6 edges, Done=1, Sh=0x80000000, Sa=31, Zero=0.
REQ-035 Start with X=0x00000001, Signed=1: Sh=0x40000000, Sa=30, Zero=0.
REQ-036 Start with X=0xFFFF0F00, Signed=1: Sh=0x87800000, Sa=15, Zero=0.
REQ-037 Start with X=0, Signed=0: Sa=31, Sh=0, Zero=1; and X=0xFFFFFFFF, Signed=1: Sa=31, Sh=0x80000000, Zero=1.
REQ-038 Start with X=0x80000000, Signed=0, pulse Start again at edge E+2 and E+3: one Done only, at E+5, with Sa=0; then a Start in the Done cycle yields a second Done 6 edges later.
REQ-039 Start, then assert Clrn=0 at edge E+3: Busy and Sh fall to 0 without waiting for Clk, no Done; 1000 random X/Signed operations after reset checked against a reference model (REQ-028/029 invariants plus Sa).

Source files
------------

// File: rtl/serial_normalizer_32.sv
// Multi-cycle 32-bit normalizer: binary-search left shift that removes leading zeros
// (unsigned mode) or redundant sign bits (signed mode) in five fixed steps of 16/8/4/2/1.
module serial_normalizer_32 (
  input  logic        clk,
  input  logic        clrn,
  input  logic        start,
  input  logic [31:0] x,
  input  logic        signed_mode,
  output logic        busy,
  output logic        done,
  output logic [31:0] sh,
  output logic [4:0]  sa,
  output logic        zero
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [2:0]  k_q, k_d;
  logic [31:0] w_q, w_d;
  logic [4:0]  a_q, a_d;
  logic        m_q, m_d;
  logic        done_q, done_d;
  logic        zero_q, zero_d;

  logic [5:0]  n;
  logic [31:0] w_shift;
  logic        hit;

  // Step test: top n bits all zero (unsigned) or top n+1 bits all equal to the sign (signed).
  always_comb begin
    n       = 6'd1 << k_q;
    w_shift = w_q << n;
    if (m_q) hit = ((w_q ^ {32{w_q[31]}}) >> (6'd31 - n)) == 32'd0;
    else     hit = (w_q >> (6'd32 - n)) == 32'd0;
  end

  // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    w_d     = w_q;
    a_d     = a_q;
    m_d     = m_q;
    done_d  = 1'b0;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          w_d     = x;
          a_d     = 5'd0;
          m_d     = signed_mode;
          k_d     = 3'd4;
        end
      end
      RUN: begin
        if (hit) begin
          w_d = w_shift;
          a_d = a_q + n[4:0];
        end
        if (k_q == 3'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
          // Zero flag is judged on the fully shifted word.
          zero_d  = m_q ? (w_d[30:0] == 31'd0) : (w_d == 32'd0);
        end else begin
          k_d = k_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      k_q     <= 3'd0;
      w_q     <= 32'd0;
      a_q     <= 5'd0;
      m_q     <= 1'b0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      w_q     <= w_d;
      a_q     <= a_d;
      m_q     <= m_d;
      done_q  <= done_d;
      zero_q  <= zero_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign sh   = w_q;
  assign sa   = a_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_serial_normalizer_32.sv
// Self-checking bench for serial_normalizer_32: directed corner cases, busy/abort
// behaviour, and randomized operations against a leading-bit-count reference model.
module tb_serial_normalizer_32;

  logic        clk;
  logic        clrn;
  logic        start;
  logic [31:0] x;
  logic        signed_mode;
  logic        busy;
  logic        done;
  logic [31:0] sh;
  logic [4:0]  sa;
  logic        zero;

  int n_cmp = 0;
  int n_err = 0;

  serial_normalizer_32 dut (
    .clk         (clk),
    .clrn        (clrn),
    .start       (start),
    .x           (x),
    .signed_mode (signed_mode),
    .busy        (busy),
    .done        (done),
    .sh          (sh),
    .sa          (sa),
    .zero        (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: count leading zeros, or sign copies beyond bit 31, capped at 31.
  function automatic void model(input logic [31:0] xv, input logic s,
                                output logic [31:0] esh, output logic [4:0] esa,
                                output logic ez);
    int cnt;
    cnt = 0;
    if (!s) begin
      for (int i = 31; i >= 0; i--) begin
        if (xv[i] != 1'b0) break;
        cnt++;
      end
    end else begin
      for (int i = 30; i >= 0; i--) begin
        if (xv[i] != xv[31]) break;
        cnt++;
      end
    end
    if (cnt > 31) cnt = 31;
    esa = cnt[4:0];
    esh = xv << cnt;
    ez  = s ? (esh[30:0] == 31'd0) : (esh == 32'd0);
  endfunction

  // Launch one operation, scramble inputs after acceptance, wait for done and check it.
  task automatic run_op(input string tag, input logic [31:0] xv, input logic s,
                        input logic [31:0] esh, input logic [4:0] esa, input logic ez);
    int lat;
    start = 1'b1; x = xv; signed_mode = s;
    tick();
    start = 1'b0; x = $urandom; signed_mode = 1'($urandom);
    check({tag, ".busy"}, busy, 1);
    lat = 0;
    while (lat < 12) begin
      tick();
      lat++;
      if (done) break;
    end
    check({tag, ".lat"}, lat, 5);
    check({tag, ".sh"}, sh, esh);
    check({tag, ".sa"}, sa, esa);
    check({tag, ".zero"}, zero, ez);
    check({tag, ".busy_done"}, busy, 0);
    if (!ez) begin
      if (!s) check({tag, ".inv_u"}, sh[31], 1);
      else    check({tag, ".inv_s"}, sh[31] ^ sh[30], 1);
    end
    tick();
    check({tag, ".done_pulse"}, done, 0);
  endtask

  initial begin
    logic [31:0] esh, xv, r;
    logic [4:0]  esa;
    logic        ez, s;
    int          dcount;

    clrn = 1'b0; start = 1'b0; x = 32'h0; signed_mode = 1'b0;
    #1;
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.sh", sh, 0);
    check("rst.sa", sa, 0);
    check("rst.zero", zero, 0);
    #22 clrn = 1'b1;
    tick();
    check("idle.busy", busy, 0);

    // Directed corner cases.
    run_op("one_u", 32'h0000_0001, 1'b0, 32'h8000_0000, 5'd31, 1'b0);
    run_op("one_s", 32'h0000_0001, 1'b1, 32'h4000_0000, 5'd30, 1'b0);
    run_op("ff0f_s", 32'hFFFF_0F00, 1'b1, 32'h8780_0000, 5'd15, 1'b0);
    run_op("zero_u", 32'h0000_0000, 1'b0, 32'h0000_0000, 5'd31, 1'b1);
    run_op("ones_s", 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 5'd31, 1'b1);
    run_op("norm_u", 32'hA5A5_5A5A, 1'b0, 32'hA5A5_5A5A, 5'd0, 1'b0);
    run_op("norm_s", 32'h5A5A_A5A5, 1'b1, 32'h5A5A_A5A5, 5'd0, 1'b0);

    // Start while busy is ignored; start in the done cycle is accepted.
    start = 1'b1; x = 32'h8000_0000; signed_mode = 1'b0;
    tick();                                  // E
    start = 1'b0; x = 32'h0000_0001;
    tick();                                  // E+1
    start = 1'b1;
    tick();                                  // E+2
    tick();                                  // E+3
    start = 1'b0;
    tick();                                  // E+4
    check("busy_start.early_done", done, 0);
    tick();                                  // E+5
    check("busy_start.done", done, 1);
    check("busy_start.sa", sa, 0);
    check("busy_start.sh", sh, 32'h8000_0000);
    start = 1'b1; x = 32'h0000_0001; signed_mode = 1'b0;
    tick();                                  // E+6
    start = 1'b0;
    check("back2back.done_clr", done, 0);
    check("back2back.busy", busy, 1);
    dcount = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) dcount++;
    end
    check("back2back.no_early", dcount, 0);
    tick();                                  // E+11
    check("back2back.done", done, 1);
    check("back2back.sa", sa, 31);
    check("back2back.sh", sh, 32'h8000_0000);
    tick();

    // Asynchronous abort mid-run.
    start = 1'b1; x = 32'h0000_1234; signed_mode = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2 clrn = 1'b0;
    #1;
    check("abort.busy", busy, 0);
    check("abort.sh", sh, 0);
    check("abort.sa", sa, 0);
    dcount = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) dcount++;
    end
    check("abort.no_done", dcount, 0);
    #2 clrn = 1'b1;
    tick();
    run_op("after_rst", 32'h0000_00F0, 1'b0, 32'hF000_0000, 5'd24, 1'b0);

    // Randomized operations with varied leading-bit runs.
    for (int i = 0; i < 1000; i++) begin
      s = 1'($urandom);
      r = $urandom;
      case ($urandom_range(0, 3))
        0:       xv = r;
        1:       xv = r >> $urandom_range(0, 31);
        2:       xv = 32'($signed(r) >>> $urandom_range(0, 31));
        default: xv = (r[0]) ? 32'hFFFF_FFFF : 32'h0;
      endcase
      model(xv, s, esh, esa, ez);
      run_op("rand", xv, s, esh, esa, ez);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
